// File: rtl/debug_scheduler.sv
// Chooses which debug word drives the shared LED bank: manual stepping, timed auto-rotation,
// and (with DEBUG_SCHED_URGENT_EN defined) urgent preemption with save/restore of the prior source.
module debug_scheduler #(
  parameter int WIDTH        = 8,
  parameter int N_SRC        = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int HOLD_CYCLES  = 1024
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     i_next,
  input  logic                     i_mode_toggle,
  input  logic [N_SRC-1:0]         i_en,
  input  logic [N_SRC-1:0]         i_urgent,
  input  logic [WIDTH-1:0]         i_src [N_SRC-1:0],
  output logic [WIDTH-1:0]         o_out,
  output logic [$clog2(N_SRC)-1:0] o_sel,
  output logic                     o_auto,
  output logic                     o_urgent_active
);

  localparam int SW = $clog2(N_SRC);
  localparam int DW = $clog2(DWELL_CYCLES);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    URGENT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SW-1:0]    adv_sel;
  logic             dwell_done;

  assign dwell_done = (dwell_q == DW'(DWELL_CYCLES - 1));

  // Next enabled source after sel in wrap order; holds when no other source is enabled.
  always_comb begin
    logic [SW:0] idx;
    logic        found;
    adv_sel = sel_q;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k < N_SRC; k++) begin
      idx = {1'b0, sel_q} + (SW+1)'(k);
      if (idx >= (SW+1)'(N_SRC)) idx = idx - (SW+1)'(N_SRC);
      if (!found && i_en[idx[SW-1:0]]) begin
        adv_sel = idx[SW-1:0];
        found   = 1'b1;
      end
    end
  end

`ifdef DEBUG_SCHED_URGENT_EN
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [N_SRC-1:0] urg_en;
  logic             urg_any;
  logic [SW-1:0]    urg_sel;
  logic [HW-1:0]    hold_q, hold_d;
  logic [SW-1:0]    saved_sel_q, saved_sel_d;
  logic             saved_auto_q, saved_auto_d;

  assign urg_en  = i_urgent & i_en;
  assign urg_any = |urg_en;

  // Descending scan so the lowest-index urgent source wins.
  always_comb begin
    urg_sel = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (urg_en[k]) urg_sel = SW'(k);
    end
  end
`else
  logic unused_urgent;
  localparam int unused_hold_cycles = HOLD_CYCLES;
  assign unused_urgent = ^i_urgent;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dwell_d = dwell_q;
`ifdef DEBUG_SCHED_URGENT_EN
    hold_d       = hold_q;
    saved_sel_d  = saved_sel_q;
    saved_auto_d = saved_auto_q;
`endif
    case (state_q)
      MANUAL, AUTO: begin
`ifdef DEBUG_SCHED_URGENT_EN
        if (urg_any) begin
          // Preemption beats i_next and dwell expiry; a same-cycle toggle lands in the saved mode.
          state_d      = URGENT;
          saved_sel_d  = sel_q;
          saved_auto_d = (state_q == AUTO) ^ i_mode_toggle;
          sel_d        = urg_sel;
          hold_d       = '0;
        end else
`endif
        if (state_q == MANUAL) begin
          if (i_next) sel_d = adv_sel;
          if (i_mode_toggle) begin
            state_d = AUTO;
            dwell_d = '0;
          end
        end else begin
          if (i_next || dwell_done) begin
            sel_d   = adv_sel;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
          if (i_mode_toggle) state_d = MANUAL;
        end
      end
`ifdef DEBUG_SCHED_URGENT_EN
      URGENT: begin
        if (hold_q < HW'(HOLD_CYCLES - 1)) hold_d = hold_q + HW'(1);
        if (i_mode_toggle) saved_auto_d = ~saved_auto_q;
        if (urg_any) begin
          sel_d = urg_sel;
        end else if (hold_q >= HW'(HOLD_CYCLES - 1)) begin
          state_d = saved_auto_d ? AUTO : MANUAL;
          sel_d   = saved_sel_q;
          dwell_d = '0;
        end
      end
`endif
      default: begin
        state_d = MANUAL;
        sel_d   = '0;
      end
    endcase
    out_d = i_en[sel_d] ? i_src[sel_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= MANUAL;
      sel_q   <= '0;
      dwell_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
    end
  end

`ifdef DEBUG_SCHED_URGENT_EN
  always_ff @(posedge clk) begin
    if (i_reset) begin
      hold_q       <= '0;
      saved_sel_q  <= '0;
      saved_auto_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      saved_sel_q  <= saved_sel_d;
      saved_auto_q <= saved_auto_d;
    end
  end

  assign o_auto          = (state_q == AUTO) || ((state_q == URGENT) && saved_auto_q);
  assign o_urgent_active = (state_q == URGENT);
`else
  assign o_auto          = (state_q == AUTO);
  assign o_urgent_active = 1'b0;
`endif

  assign o_out = out_q;
  assign o_sel = sel_q;

endmodule

// File: tb/tb_debug_scheduler.sv
// Scoreboard bench for debug_scheduler (DWELL_CYCLES=4, HOLD_CYCLES=8); expected words are
// {urgent_active, auto, sel, out} queued with each stimulus and checked one cycle later.
module tb_debug_scheduler;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_next;
  logic       i_mode_toggle;
  logic [3:0] i_en;
  logic [3:0] i_urgent;
  logic [7:0] src [3:0];
  logic [7:0] o_out;
  logic [1:0] o_sel;
  logic       o_auto;
  logic       o_urgent_active;

  int n_cmp = 0;
  int n_mis = 0;

  string       nm_q [$];
  logic [11:0] ex_q [$];

  debug_scheduler #(
    .WIDTH(8), .N_SRC(4), .DWELL_CYCLES(4), .HOLD_CYCLES(8)
  ) dut (
    .clk(clk),
    .i_reset(i_reset),
    .i_next(i_next),
    .i_mode_toggle(i_mode_toggle),
    .i_en(i_en),
    .i_urgent(i_urgent),
    .i_src(src),
    .o_out(o_out),
    .o_sel(o_sel),
    .o_auto(o_auto),
    .o_urgent_active(o_urgent_active)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {o_urgent_active, o_auto, o_sel, o_out};
  endfunction

  function automatic logic [11:0] ev(input logic u, input logic a, input logic [1:0] s,
                                     input logic [7:0] o);
    return {u, a, s, o};
  endfunction

  function automatic logic [7:0] srcv(input logic [1:0] s);
    case (s)
      2'd0: return 8'h11;
      2'd1: return 8'h22;
      2'd2: return 8'h33;
      default: return 8'h44;
    endcase
  endfunction

  task automatic cyc(input logic nx, input logic tg, input logic rst, input logic [3:0] ug);
    i_next = nx; i_mode_toggle = tg; i_reset = rst; i_urgent = ug;
    @(posedge clk); #1;
    i_next = 1'b0; i_mode_toggle = 1'b0;
  endtask

  task automatic test_reset();
    string nm; logic [11:0] ex, got;
    for (int i = 0; i < 2; i++) begin
      nm_q.push_back($sformatf("reset_%0d", i));
      ex_q.push_back(i == 0 ? ev(0, 0, 2'd0, 8'h00) : ev(0, 0, 2'd0, 8'h11));
      cyc(1'b0, 1'b0, (i == 0), 4'b0000);
      got = obs(); nm = nm_q.pop_front(); ex = ex_q.pop_front(); n_cmp++;
      if (got !== ex) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, ex); end
      else $display("ok   %s: %h", nm, got);
    end
  endtask

  task automatic test_manual();
    string nm; logic [11:0] ex, got;
    for (int i = 0; i < 4; i++) begin
      nm_q.push_back($sformatf("manual_next_%0d", i));
      ex_q.push_back(ev(0, 0, 2'((i + 1) % 4), srcv(2'((i + 1) % 4))));
      cyc(1'b1, 1'b0, 1'b0, 4'b0000);
      got = obs(); nm = nm_q.pop_front(); ex = ex_q.pop_front(); n_cmp++;
      if (got !== ex) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, ex); end
      else $display("ok   %s: %h", nm, got);
    end
  endtask

  task automatic test_enable_mask();
    string nm; logic [11:0] ex, got;
    logic [3:0]  en_t [6];
    logic        nx_t [6];
    logic [11:0] ex_t [6];
    en_t = '{4'b1111, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0010};
    nx_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ex_t[0] = ev(0, 0, 2'd1, 8'h22);
    ex_t[1] = ev(0, 0, 2'd3, 8'h44);
    ex_t[2] = ev(0, 0, 2'd1, 8'h22);
    ex_t[3] = ev(0, 0, 2'd1, 8'h00);
    ex_t[4] = ev(0, 0, 2'd1, 8'h00);
    ex_t[5] = ev(0, 0, 2'd1, 8'h22);
    for (int i = 0; i < 6; i++) begin
      i_en = en_t[i];
      nm_q.push_back($sformatf("mask_%0d_en%b", i, en_t[i]));
      ex_q.push_back(ex_t[i]);
      cyc(nx_t[i], 1'b0, 1'b0, 4'b0000);
      got = obs(); nm = nm_q.pop_front(); ex = ex_q.pop_front(); n_cmp++;
      if (got !== ex) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, ex); end
      else $display("ok   %s: %h", nm, got);
    end
    i_en = 4'b1111;
  endtask

  // Enters AUTO at sel 1; i_next two cycles into a dwell at row 7, coincident with expiry at row 15.
  task automatic test_auto();
    string nm; logic [11:0] ex, got;
    int sel_t [20] = '{1,1,1,1, 2,2,2,3, 3,3,3,0, 0,0,0,1, 1,1,1,2};
    for (int i = 0; i < 20; i++) begin
      nm_q.push_back($sformatf("auto_%0d", i));
      ex_q.push_back(ev(0, 1, 2'(sel_t[i]), srcv(2'(sel_t[i]))));
      cyc((i == 7 || i == 15), (i == 0), 1'b0, 4'b0000);
      got = obs(); nm = nm_q.pop_front(); ex = ex_q.pop_front(); n_cmp++;
      if (got !== ex) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, ex); end
      else $display("ok   %s: %h", nm, got);
    end
  endtask

`ifdef DEBUG_SCHED_URGENT_EN
  // AUTO at sel 2, source 3 urgent for 2 cycles: 8 cycles of URGENT, restore, then a full dwell.
  task automatic test_urgent_preempt();
    string nm; logic [11:0] ex, got;
    for (int i = 0; i < 13; i++) begin
      nm_q.push_back($sformatf("urgent_preempt_%0d", i));
      if (i < 8)       ex_q.push_back(ev(1, 1, 2'd3, 8'h44));
      else if (i < 12) ex_q.push_back(ev(0, 1, 2'd2, 8'h33));
      else             ex_q.push_back(ev(0, 1, 2'd3, 8'h44));
      cyc(1'b0, 1'b0, 1'b0, (i < 2) ? 4'b1000 : 4'b0000);
      got = obs(); nm = nm_q.pop_front(); ex = ex_q.pop_front(); n_cmp++;
      if (got !== ex) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, ex); end
      else $display("ok   %s: %h", nm, got);
    end
  endtask

  task automatic test_urgent_track();
    string nm; logic [11:0] ex, got;
    logic [3:0]  ug_t [10] = '{4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b0000,
                               4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [11:0] ex_t [10];
    ex_t[0] = ev(1, 1, 2'd3, 8'h44);
    ex_t[1] = ev(1, 1, 2'd0, 8'h11);
    ex_t[2] = ev(1, 1, 2'd0, 8'h11);
    for (int i = 3; i < 8; i++) ex_t[i] = ev(1, 0, 2'd0, 8'h11);
    ex_t[8] = ev(0, 0, 2'd3, 8'h44);
    ex_t[9] = ev(0, 0, 2'd3, 8'h44);
    for (int i = 0; i < 10; i++) begin
      nm_q.push_back($sformatf("urgent_track_%0d", i));
      ex_q.push_back(ex_t[i]);
      cyc((i == 2), (i == 3), 1'b0, ug_t[i]);
      got = obs(); nm = nm_q.pop_front(); ex = ex_q.pop_front(); n_cmp++;
      if (got !== ex) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, ex); end
      else $display("ok   %s: %h", nm, got);
    end
  endtask

  task automatic test_urgent_reset();
    string nm; logic [11:0] ex, got;
    logic [11:0] ex_t [3];
    ex_t[0] = ev(1, 0, 2'd0, 8'h11);
    ex_t[1] = ev(0, 0, 2'd0, 8'h00);
    ex_t[2] = ev(0, 0, 2'd0, 8'h11);
    for (int i = 0; i < 3; i++) begin
      nm_q.push_back($sformatf("urgent_reset_%0d", i));
      ex_q.push_back(ex_t[i]);
      cyc(1'b0, 1'b0, (i == 1), (i < 2) ? 4'b0001 : 4'b0000);
      got = obs(); nm = nm_q.pop_front(); ex = ex_q.pop_front(); n_cmp++;
      if (got !== ex) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, ex); end
      else $display("ok   %s: %h", nm, got);
    end
  endtask
`else
  // Urgent requests must be ignored; back to MANUAL first, then reset to a known state.
  task automatic test_urgent_ignored();
    string nm; logic [11:0] ex, got;
    logic [11:0] ex_t [5];
    ex_t[0] = ev(0, 0, 2'd2, 8'h33);
    ex_t[1] = ev(0, 0, 2'd2, 8'h33);
    ex_t[2] = ev(0, 0, 2'd3, 8'h44);
    ex_t[3] = ev(0, 0, 2'd0, 8'h00);
    ex_t[4] = ev(0, 0, 2'd0, 8'h11);
    for (int i = 0; i < 5; i++) begin
      nm_q.push_back($sformatf("urgent_ignored_%0d", i));
      ex_q.push_back(ex_t[i]);
      cyc((i == 2), (i == 0), (i == 3), (i < 4) ? 4'b1111 : 4'b0000);
      got = obs(); nm = nm_q.pop_front(); ex = ex_q.pop_front(); n_cmp++;
      if (got !== ex) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, ex); end
      else $display("ok   %s: %h", nm, got);
    end
  endtask
`endif

  // Simultaneous next+toggle, source word change latency, and live enable masking.
  task automatic test_back_to_back();
    string nm; logic [11:0] ex, got;
    logic [11:0] ex_t [5];
    ex_t[0] = ev(0, 1, 2'd1, 8'h22);
    ex_t[1] = ev(0, 0, 2'd2, 8'h33);
    ex_t[2] = ev(0, 0, 2'd2, 8'hA5);
    ex_t[3] = ev(0, 0, 2'd2, 8'h33);
    ex_t[4] = ev(0, 0, 2'd2, 8'h00);
    for (int i = 0; i < 5; i++) begin
      src[2] = (i == 2) ? 8'hA5 : 8'h33;
      i_en   = (i == 4) ? 4'b1011 : 4'b1111;
      nm_q.push_back($sformatf("back_to_back_%0d", i));
      ex_q.push_back(ex_t[i]);
      cyc((i < 2), (i < 2), 1'b0, 4'b0000);
      got = obs(); nm = nm_q.pop_front(); ex = ex_q.pop_front(); n_cmp++;
      if (got !== ex) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, ex); end
      else $display("ok   %s: %h", nm, got);
    end
    i_en = 4'b1111;
  endtask

  initial begin
    i_reset = 1'b1; i_next = 1'b0; i_mode_toggle = 1'b0;
    i_en = 4'b1111; i_urgent = 4'b0000;
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
    test_reset();
    test_manual();
    test_enable_mask();
    test_auto();
`ifdef DEBUG_SCHED_URGENT_EN
    test_urgent_preempt();
    test_urgent_track();
    test_urgent_reset();
`else
    test_urgent_ignored();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/debug_scheduler.md
# debug_scheduler

Sequences which debug word drives the shared 8-bit LED bank. It replaces the free-running click mux with a scheduler that supports manual stepping, timed auto-rotation and urgent preemption across N sources with a per-source enable mask. It sits between the button debouncers (single-cycle click pulses) and the LED-side output debouncers inside the debug subsystem.

## Interface
- WIDTH, 8, bits per debug word / LED bank width
- N_SRC, 4, number of debug sources (≥2)
- DWELL_CYCLES, 50_000_000, auto-mode dwell per source in clk cycles (≥2)
- HOLD_CYCLES, 1024, minimum urgent-mode hold in clk cycles (≥1)

Ports:
- clk  in  1  system clock; one clock domain
- i_reset  in  1  synchronous, active-high reset
- i_next  in  1  single-cycle pulse (debounced click): advance source
- i_mode_toggle  in  1  single-cycle pulse: toggle manual/auto
- i_en  in  N_SRC  source enable mask
- i_urgent  in  N_SRC  level urgent request per source
- i_src  in  WIDTH × N_SRC (unpacked array [N_SRC-1:0])  source words
- o_out  out  WIDTH  selected word, registered
- o_sel  out  $clog2(N_SRC)  current source index
- o_auto  out  1  1 = auto mode (including auto saved under urgent)
- o_urgent_active  out  1  1 while in URGENT

## Operation
- States: MANUAL, AUTO, URGENT. Registers: sel, saved_sel, saved_mode, dwell timer, hold timer.
- Reset: state MANUAL, sel=0, all timers 0, o_out=0, o_sel=0, o_auto=0, o_urgent_active=0. Reset mid-operation aborts any mode, including URGENT, on the same edge.
- Advance: the next index after sel with i_en set, searched in wrap order (N_SRC-1 → 0). If no other source is enabled, sel holds. If i_en is all zero, sel holds.
- MANUAL: i_next advances. i_mode_toggle → AUTO and clears the dwell timer.
- AUTO: the dwell timer counts every cycle. At DWELL_CYCLES-1 it advances and clears. i_next advances immediately and clears the timer. Timer expiry coincident with i_next gives one advance only. i_mode_toggle → MANUAL.
- Simultaneous i_next and i_mode_toggle: both apply on the same edge (advance plus mode change).
- URGENT entry: from MANUAL or AUTO when (i_urgent & i_en) ≠ 0.
  - Save sel and mode; sel = lowest-index urgent enabled source; hold timer cleared.
  - Urgent has priority over i_next and dwell expiry that same cycle.
- In URGENT:
  - sel tracks the lowest-index active urgent source.
  - i_next is ignored.
  - i_mode_toggle flips saved_mode.
  - The dwell timer is frozen.
- URGENT exit: when the hold timer ≥ HOLD_CYCLES-1 and (i_urgent & i_en) = 0.
  - Return to saved_mode; sel = saved_sel; dwell timer cleared.
- Output masking: o_out = 0 whenever i_en[sel] = 0; otherwise o_out = i_src[sel].
- Index arithmetic is modulo N_SRC. For non-power-of-2 N_SRC, sel never holds a value ≥ N_SRC.

## Timing
- All outputs are registered.
- o_sel and o_out update on the same edge: one cycle after the causing input.
- o_out follows changes on i_src[sel] with 1-cycle latency.
- Auto period: exactly DWELL_CYCLES cycles between successive o_sel changes with no other input.
- URGENT minimum residency: HOLD_CYCLES cycles.
- Restore to the saved source appears 1 cycle after the exit condition.
- No combinational path from inputs to outputs.

## Configuration
- DEBUG_SCHED_URGENT_EN defined: URGENT state and preemption present as described.
- Not defined:
  - i_urgent is ignored; the URGENT state, hold timer and saved registers are absent.
  - o_urgent_active is tied 0.
  - MANUAL/AUTO behaviour is unchanged.

## Test plan
- Reset, MANUAL, i_en=4'b1111, i_src={8'h44,8'h33,8'h22,8'h11}: three i_next pulses → o_sel 1,2,3 and o_out 8'h22,8'h33,8'h44, each 1 cycle after its pulse. A fourth pulse wraps to o_sel=0, o_out=8'h11.
- i_en=4'b1010, sel=1, i_next → o_sel=3. A second i_next → o_sel=1. Set i_en=4'b0000 → o_out=0 and o_sel holds.
- DWELL_CYCLES=4, i_mode_toggle → o_auto=1; o_sel steps every 4 cycles. An i_next 2 cycles into a dwell gives an immediate step, then the next step 4 cycles later. i_next coincident with expiry gives a single step.
- HOLD_CYCLES=8, AUTO at sel=2, i_urgent=4'b1000 for 2 cycles → o_urgent_active=1, o_sel=3 for 8 cycles. Then o_sel=2, o_auto=1, and a full 4-cycle dwell follows.
- During URGENT, i_urgent changes 4'b1000→4'b1001 → o_sel=0. i_next is ignored. i_mode_toggle → exit lands in MANUAL.
- i_reset asserted in URGENT → next cycle o_sel=0, o_out=0, o_auto=0, o_urgent_active=0. With the macro undefined, i_urgent=4'b1111 has no effect.
